// File: rtl/control_memory.sv
// control_memory: load/store stage between execute and register write-back.
// Issues one word-aligned data-memory transaction per instruction, extends
// load data and hands load results to the register file.
module control_memory #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pre_valid,
    output logic                      pre_ready,
    input  logic [6:0]                pre_opcode,
    input  logic [2:0]                pre_funct3,
    input  logic [DATA_WIDTH-1:0]     pre_rs2_data,
    input  logic [REG_ADDR_WIDTH-1:0] pre_rd_addr,
    input  logic [ADDR_WIDTH-1:0]     pre_alu_result,
    output logic                      dmem_req_valid,
    input  logic                      dmem_req_ready,
    output logic                      dmem_we,
    output logic [ADDR_WIDTH-1:0]     dmem_addr,
    output logic [DATA_WIDTH-1:0]     dmem_wdata,
    output logic [3:0]                dmem_wstrb,
    input  logic                      dmem_resp_valid,
    input  logic [DATA_WIDTH-1:0]     dmem_rdata,
    output logic                      fwd_req,
    input  logic                      fwd_resp,
    output logic [REG_ADDR_WIDTH-1:0] fwd_addr,
    output logic [DATA_WIDTH-1:0]     fwd_data,
    output logic                      misalign_err
);

    localparam logic [6:0]  OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  OP_STORE = 7'b0100011;
    localparam int unsigned STRB_W   = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WB,
        S_ERR
    } state_e;

    state_e                    state_q, state_d;
    logic                      we_q, we_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [STRB_W-1:0]         wstrb_q, wstrb_d;
    logic [2:0]                funct3_q, funct3_d;
    logic [1:0]                off_q, off_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [DATA_WIDTH-1:0]     fwd_data_q, fwd_data_d;
    logic                      req_valid_q, req_valid_d;
    logic                      fwd_req_q, fwd_req_d;
    logic                      misalign_q, misalign_d;

    logic                      acc_load, acc_store, acc_byte, acc_half, acc_mis;
    logic [1:0]                acc_off;
    logic [STRB_W-1:0]         acc_strb;
    logic [DATA_WIDTH-1:0]     acc_wdata;
    logic [15:0]               ld_shift;
    logic [DATA_WIDTH-1:0]     ld_val;

    // Decode the incoming instruction: access size, alignment, store lanes.
    // Undefined funct3 values fall back to a full-word access.
    always_comb begin
        acc_load  = (pre_opcode == OP_LOAD);
        acc_store = (pre_opcode == OP_STORE);
        acc_byte  = (pre_funct3 == 3'b000) || (acc_load && pre_funct3 == 3'b100);
        acc_half  = (pre_funct3 == 3'b001) || (acc_load && pre_funct3 == 3'b101);
        acc_off   = pre_alu_result[1:0];
        acc_mis   = (acc_half && acc_off[0]) ||
                    (!acc_byte && !acc_half && acc_off != 2'b00);
        if (!acc_store) begin
            acc_strb = '0;
        end else if (acc_byte) begin
            acc_strb = 4'b0001 << acc_off;
        end else if (acc_half) begin
            acc_strb = 4'b0011 << acc_off;
        end else begin
            acc_strb = 4'b1111;
        end
        if (acc_byte) begin
            acc_wdata = {4{pre_rs2_data[7:0]}};
        end else if (acc_half) begin
            acc_wdata = {2{pre_rs2_data[15:0]}};
        end else begin
            acc_wdata = pre_rs2_data;
        end
    end

    // Select the addressed byte/half of the read word and extend it.
    always_comb begin
        ld_shift = 16'(dmem_rdata >> {off_q, 3'b000});
        case (funct3_q)
            3'b000:  ld_val = {{(DATA_WIDTH-8){ld_shift[7]}}, ld_shift[7:0]};
            3'b100:  ld_val = DATA_WIDTH'(ld_shift[7:0]);
            3'b001:  ld_val = {{(DATA_WIDTH-16){ld_shift[15]}}, ld_shift};
            3'b101:  ld_val = DATA_WIDTH'(ld_shift);
            default: ld_val = dmem_rdata;
        endcase
    end

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        funct3_d   = funct3_q;
        off_d      = off_q;
        rd_d       = rd_q;
        fwd_data_d = fwd_data_q;
        case (state_q)
            S_IDLE: begin
                if (pre_valid) begin
                    we_d     = acc_store;
                    addr_d   = {pre_alu_result[ADDR_WIDTH-1:2], 2'b00};
                    wdata_d  = acc_wdata;
                    wstrb_d  = acc_strb;
                    funct3_d = pre_funct3;
                    off_d    = acc_off;
                    rd_d     = pre_rd_addr;
                    if (acc_load || acc_store) begin
                        state_d = acc_mis ? S_ERR : S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (dmem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dmem_resp_valid) begin
                    if (we_q) begin
                        state_d = S_IDLE;
                    end else begin
                        fwd_data_d = ld_val;
                        state_d    = (rd_q == '0) ? S_IDLE : S_WB;
                    end
                end
            end
            S_WB: begin
                if (fwd_resp) begin
                    state_d = S_IDLE;
                end
            end
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        req_valid_d = (state_d == S_REQ);
        fwd_req_d   = (state_d == S_WB);
        misalign_d  = (state_d == S_ERR);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            funct3_q    <= '0;
            off_q       <= '0;
            rd_q        <= '0;
            fwd_data_q  <= '0;
            req_valid_q <= 1'b0;
            fwd_req_q   <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            rd_q        <= rd_d;
            fwd_data_q  <= fwd_data_d;
            req_valid_q <= req_valid_d;
            fwd_req_q   <= fwd_req_d;
            misalign_q  <= misalign_d;
        end
    end

    assign pre_ready      = (state_q == S_IDLE);
    assign dmem_req_valid = req_valid_q;
    assign dmem_we        = we_q;
    assign dmem_addr      = addr_q;
    assign dmem_wdata     = wdata_q;
    assign dmem_wstrb     = wstrb_q;
    assign fwd_req        = fwd_req_q;
    assign fwd_addr       = rd_q;
    assign fwd_data       = fwd_data_q;
    assign misalign_err   = misalign_q;

endmodule

// File: doc/control_memory.md
Name: control_memory

Overview:
Memory-access pipeline stage. It sits directly downstream of the execute stage and consumes its load/store hand-off: opcode, funct3, rs2_data, rd_addr and alu_result (the effective address).
- Issues one word-aligned data-memory transaction per instruction, with byte strobes.
- Extracts and sign- or zero-extends load data.
- Delivers load results to the register file over the forward req/resp handshake.

Parameters:
DATA_WIDTH, 32, data path width (only 32 supported)
ADDR_WIDTH, 32, byte address width
REG_ADDR_WIDTH, 5, register index width

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous active-high reset
pre_valid  in  1  execute stage has a load/store for this stage
pre_ready  out  1  this stage can accept
pre_opcode  in  7  opcode (OP_LOAD 7'b0000011, OP_STORE 7'b0100011)
pre_funct3  in  3  width/sign select (RV32I encoding)
pre_rs2_data  in  DATA_WIDTH  store data
pre_rd_addr  in  REG_ADDR_WIDTH  load destination
pre_alu_result  in  ADDR_WIDTH  effective byte address
dmem_req_valid  out  1  memory request
dmem_req_ready  in  1  memory accepts request
dmem_we  out  1  1=store, 0=load
dmem_addr  out  ADDR_WIDTH  word address, bits [1:0]=0
dmem_wdata  out  DATA_WIDTH  lane-replicated store data
dmem_wstrb  out  4  byte enables; 4'b0000 for loads
dmem_resp_valid  in  1  read data valid / write ack
dmem_rdata  in  DATA_WIDTH  read word
fwd_req  out  1  register write-back request
fwd_resp  in  1  register file took write
fwd_addr  out  REG_ADDR_WIDTH  destination register
fwd_data  out  DATA_WIDTH  extended load value
misalign_err  out  1  one-cycle pulse on a misaligned access

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; pre_ready=1; dmem_req_valid=0, fwd_req=0, misalign_err=0; all data registers 0. Reset in any state aborts the operation with no further request or write-back.
- pre_ready = (state==IDLE), combinational from the state register.
- Accept: on pre_valid && pre_ready, latch all pre_* fields.
- State after accept:
  - REQ: load/store, aligned.
  - ERR: misaligned. Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - IDLE: any other opcode; the instruction is silently dropped.
- REQ: dmem_req_valid=1, first asserted the cycle after accept. Hold it, with stable address, data and strobe, until dmem_req_ready, then go to WAIT.
- WAIT:
  - dmem_resp_valid is sampled only in WAIT; it is ignored in every other state. Memory never responds in its acceptance cycle.
  - Store + resp: go to IDLE.
  - Load + resp: latch the extracted value. If rd_addr==0 go to IDLE; otherwise go to WB.
- WB: fwd_req=1, fwd_addr and fwd_data stable. On fwd_resp go to IDLE, with fwd_req=0 in that next cycle.
- ERR: misalign_err=1 for exactly one cycle; no memory access, no write-back; then IDLE.
- Address: dmem_addr = {addr[ADDR_WIDTH-1:2],2'b00}. Byte offset o = addr[1:0].
- Store lanes:
  - SB: wstrb=4'b0001<<o, wdata={4{rs2[7:0]}}.
  - SH: wstrb = 4'b0011 when o=0, 4'b1100 when o=2; wdata={2{rs2[15:0]}}.
  - SW: wstrb=4'b1111, wdata=rs2.
- Load extract:
  - LB/LBU: rdata[8o+7:8o], sign- or zero-extended.
  - LH/LHU: rdata[8o+15:8o], extended.
  - LW: full word.
  - Undefined funct3: treated as LW or SW.
- Latency:
  - Aligned store: zero-wait memory finishes in 3 cycles from accept.
  - Load: fwd_req rises 3 cycles after accept.
  - pre_ready returns the cycle after completion. Throughput is one op per 3+ cycles.
- dmem_req_valid and fwd_req are never asserted together, and never asserted in IDLE.

Test Plan:
- SW addr 0x100, rs2=0xDEADBEEF, ready/resp immediate -> dmem_addr=0x100, wstrb=1111, wdata=0xDEADBEEF, no fwd_req, pre_ready high again 3 cycles after accept.
- SB addr 0x103, rs2=0x000000A5 -> wstrb=1000, wdata=0xA5A5A5A5.
- LB addr 0x202, rd=5, rdata=0x0080FF00 -> fwd_req with fwd_addr=5, fwd_data=0xFFFFFF80. Same access as LHU at addr 0x202 -> fwd_data=0x00000080.
- LW addr 0x101 -> misalign_err pulses once, dmem_req_valid never asserted, next op accepted 2 cycles after accept. LW with rd=0 -> memory read issued, fwd_req never asserted.
- Backpressure: dmem_req_ready low for 4 cycles -> request and its fields held stable, pre_ready=0 throughout. fwd_resp delayed 3 cycles -> fwd_req and fwd_data stable until taken.
- rst asserted during WAIT of a load, then resp arrives -> no fwd_req, all outputs at reset values, pre_ready=1 the cycle after rst deasserts.
